// File: rtl/draw_pkg.sv
// Shared opcodes, field widths, word counts and FSM states for the draw command writer.
package draw_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int C_W = 3;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_RECT  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    localparam logic [3:0] HDR_RECT  = 4'h1;
    localparam logic [3:0] HDR_CLEAR = 4'h2;

    localparam logic [2:0] RECT_WORDS  = 3'd5;
    localparam logic [2:0] CLEAR_WORDS = 3'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic logic [15:0] header_word(input logic [3:0] opc, input logic [C_W-1:0] color);
        return {opc, 9'b0, color};
    endfunction

endpackage

// File: rtl/draw_clip.sv
// Combinational rectangle clipper against the screen bounds; used only when DRAW_CLIP_EN is defined.
module draw_clip
    import draw_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    input  logic [X_W-1:0] w_i,
    input  logic [Y_W-1:0] h_i,
    output logic [X_W-1:0] w_o,
    output logic [Y_W-1:0] h_o,
    output logic           drop_o
);

    logic [X_W:0] rem_w_s;
    logic [Y_W:0] rem_h_s;

    // Room left to the right/bottom edge; only meaningful when the origin is on screen.
    always_comb begin
        rem_w_s = 11'(SCREEN_W) - {1'b0, x_i};
        rem_h_s = 10'(SCREEN_H) - {1'b0, y_i};
        drop_o  = ({1'b0, x_i} >= 11'(SCREEN_W)) || ({1'b0, y_i} >= 10'(SCREEN_H));
        if ({1'b0, w_i} > rem_w_s) begin
            w_o = rem_w_s[X_W-1:0];
        end else begin
            w_o = w_i;
        end
        if ({1'b0, h_i} > rem_h_s) begin
            h_o = rem_h_s[Y_W-1:0];
        end else begin
            h_o = h_i;
        end
    end

endmodule

// File: rtl/draw_cmd_writer.sv
// Serialises draw requests into 16-bit command words for DrawUnit, honouring its full flag.
// Optional clipping against the screen is enabled by defining DRAW_CLIP_EN.
module draw_cmd_writer
    import draw_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [X_W-1:0]     req_x,
    input  logic [Y_W-1:0]     req_y,
    input  logic [X_W-1:0]     req_w,
    input  logic [Y_W-1:0]     req_h,
    input  logic [C_W-1:0]     req_color,
    input  logic               full,
    output logic               we,
    output logic [15:0]        data,
    output logic               busy,
    output logic               dropped,
    output logic [COUNT_W-1:0] cmd_count
);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         last_q, last_d;
    logic [3:0]         hdr_q, hdr_d;
    logic [X_W-1:0]     x_q, x_d, w_q, w_d;
    logic [Y_W-1:0]     y_q, y_d, h_q, h_d;
    logic [C_W-1:0]     color_q, color_d;
    logic               dropped_q, dropped_d;
    logic               live_q, live_d;
    logic [COUNT_W-1:0] cmd_count_q, cmd_count_d;

    logic [X_W-1:0] eff_w_s;
    logic [Y_W-1:0] eff_h_s;
    logic           clip_drop_s;
    logic           rect_drop_s;
    logic           accept_s;
    logic           busy_s;
    logic           we_s;
    logic [15:0]    word_s;

`ifdef DRAW_CLIP_EN
    draw_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .x_i    (req_x),
        .y_i    (req_y),
        .w_i    (req_w),
        .h_i    (req_h),
        .w_o    (eff_w_s),
        .h_o    (eff_h_s),
        .drop_o (clip_drop_s)
    );
`else
    assign eff_w_s     = req_w;
    assign eff_h_s     = req_h;
    assign clip_drop_s = 1'b0;
`endif

    // live_q keeps req_ready low for every cycle the block is held in reset.
    assign busy_s      = (state_q == ST_SEND);
    assign accept_s    = req_valid & req_ready;
    assign rect_drop_s = clip_drop_s | (req_w == 10'd0) | (req_h == 9'd0);
    assign we_s        = busy_s & ~full;

    assign req_ready = live_q & (state_q == ST_IDLE);
    assign we        = we_s;
    assign data      = word_s;
    assign busy      = busy_s;
    assign dropped   = dropped_q;
    assign cmd_count = cmd_count_q;

    // Select the word at the current index from the latched request fields.
    always_comb begin
        word_s = 16'd0;
        if (busy_s) begin
            case (idx_q)
                3'd0:    word_s = header_word(hdr_q, color_q);
                3'd1:    word_s = {6'b0, x_q};
                3'd2:    word_s = {7'b0, y_q};
                3'd3:    word_s = {6'b0, w_q};
                3'd4:    word_s = {7'b0, h_q};
                default: word_s = 16'd0;
            endcase
        end else begin
            word_s = 16'd0;
        end
    end

    // Next-state logic: accept and decode in IDLE, advance the word index in SEND.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        hdr_d       = hdr_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        dropped_d   = 1'b0;
        live_d      = 1'b1;
        cmd_count_d = cmd_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (req_op)
                        OP_RECT: begin
                            if (rect_drop_s) begin
                                dropped_d = 1'b1;
                            end else begin
                                hdr_d   = HDR_RECT;
                                last_d  = RECT_WORDS - 3'd1;
                                x_d     = req_x;
                                y_d     = req_y;
                                w_d     = eff_w_s;
                                h_d     = eff_h_s;
                                color_d = req_color;
                                idx_d   = 3'd0;
                                state_d = ST_SEND;
                            end
                        end
                        OP_CLEAR: begin
                            hdr_d   = HDR_CLEAR;
                            last_d  = CLEAR_WORDS - 3'd1;
                            color_d = req_color;
                            idx_d   = 3'd0;
                            state_d = ST_SEND;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (we_s) begin
                    if (idx_q == last_q) begin
                        idx_d       = 3'd0;
                        state_d     = ST_IDLE;
                        cmd_count_d = cmd_count_q + COUNT_W'(1);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            last_q      <= 3'd0;
            hdr_q       <= 4'h0;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            w_q         <= 10'd0;
            h_q         <= 9'd0;
            color_q     <= 3'd0;
            dropped_q   <= 1'b0;
            live_q      <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            hdr_q       <= hdr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            dropped_q   <= dropped_d;
            live_q      <= live_d;
            cmd_count_q <= cmd_count_d;
        end
    end

endmodule

// File: tb/tb_draw_cmd_writer.sv
// Table-driven bench for draw_cmd_writer plus hand sequences for reset, backpressure and mid-command reset.
module tb_draw_cmd_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [9:0]  req_x = 10'd0;
    logic [8:0]  req_y = 9'd0;
    logic [9:0]  req_w = 10'd0;
    logic [8:0]  req_h = 9'd0;
    logic [2:0]  req_color = 3'd0;
    logic        full = 1'b0;
    logic        we;
    logic [15:0] data;
    logic        busy;
    logic        dropped;
    logic [15:0] cmd_count;

    draw_cmd_writer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_color (req_color),
        .full      (full),
        .we        (we),
        .data      (data),
        .busy      (busy),
        .dropped   (dropped),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [9:0]       x;
        logic [8:0]       y;
        logic [9:0]       w;
        logic [8:0]       h;
        logic [2:0]       c;
        int               n;
        logic             drop;
        logic [4:0][15:0] words;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [1:0] op, input int x, input int y, input int w, input int h,
                                input int c, input int n, input logic drop,
                                input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                input logic [15:0] w3, input logic [15:0] w4);
        vec_t v;
        v.op = op; v.x = 10'(x); v.y = 9'(y); v.w = 10'(w); v.h = 9'(h); v.c = 3'(c);
        v.n = n; v.drop = drop;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3; v.words[4] = w4;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] got_w [5];
        int          got;
        check({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        req_op = v.op; req_x = v.x; req_y = v.y; req_w = v.w; req_h = v.h; req_color = v.c;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_dropped"}, {31'd0, dropped}, {31'd0, v.drop});
        check({tag, "_busy"}, {31'd0, busy}, (v.n > 0) ? 32'd1 : 32'd0);
        got = 0;
        for (int c = 0; c < 40 && got < v.n; c++) begin
            if (we) begin
                if (got < 5) got_w[got] = data;
                got++;
            end
            tick();
        end
        check({tag, "_nwords"}, got, v.n);
        for (int k = 0; k < v.n && k < got; k++) begin
            check($sformatf("%s_word%0d", tag, k), {16'd0, got_w[k]}, {16'd0, v.words[k]});
        end
        if (v.n == 0) begin
            tick();
            check({tag, "_no_we"}, {31'd0, we}, 32'd0);
            check({tag, "_pulse_once"}, {31'd0, dropped}, 32'd0);
        end else begin
            exp_count++;
        end
        check({tag, "_cmd_count"}, {16'd0, cmd_count}, exp_count);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        vec_t clr;

        add(2'd1, 10, 20, 30, 40, 5, 5, 1'b0, 16'h1005, 16'h000A, 16'h0014, 16'h001E, 16'h0028);
        add(2'd2, 0, 0, 0, 0, 3, 1, 1'b0, 16'h2003, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd1, 5, 5, 0, 7, 1, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd1, 5, 5, 7, 0, 1, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd0, 1, 2, 3, 4, 5, 0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd3, 1, 2, 3, 4, 5, 0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd1, 639, 479, 1, 1, 0, 5, 1'b0, 16'h1000, 16'h027F, 16'h01DF, 16'h0001, 16'h0001);
`ifdef DRAW_CLIP_EN
        add(2'd1, 600, 470, 100, 50, 2, 5, 1'b0, 16'h1002, 16'h0258, 16'h01D6, 16'h0028, 16'h000A);
        add(2'd1, 640, 0, 5, 5, 1, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd1, 0, 480, 3, 3, 4, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add(2'd1, 1023, 511, 1023, 511, 7, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
`else
        add(2'd1, 600, 470, 100, 50, 2, 5, 1'b0, 16'h1002, 16'h0258, 16'h01D6, 16'h0064, 16'h0032);
        add(2'd1, 640, 0, 5, 5, 1, 5, 1'b0, 16'h1001, 16'h0280, 16'h0000, 16'h0005, 16'h0005);
        add(2'd1, 0, 480, 3, 3, 4, 5, 1'b0, 16'h1004, 16'h0000, 16'h01E0, 16'h0003, 16'h0003);
        add(2'd1, 1023, 511, 1023, 511, 7, 5, 1'b0, 16'h1007, 16'h03FF, 16'h01FF, 16'h03FF, 16'h01FF);
`endif

        // Reset held with a pending request: outputs stay quiet, no acceptance.
        reset = 1'b0; req_valid = 1'b1; req_op = 2'd2; req_color = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d_we", i), {31'd0, we}, 32'd0);
            check($sformatf("rst%0d_data", i), {16'd0, data}, 32'd0);
            check($sformatf("rst%0d_ready", i), {31'd0, req_ready}, 32'd0);
            check($sformatf("rst%0d_count", i), {16'd0, cmd_count}, 32'd0);
        end
        reset = 1'b1; req_valid = 1'b0;
        tick();
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        check("rst_release_busy", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: CLEAR held for 4 cycles, written the cycle full drops.
        full = 1'b1;
        req_op = 2'd2; req_color = 3'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp%0d_we", i), {31'd0, we}, 32'd0);
            check($sformatf("bp%0d_data", i), {16'd0, data}, 32'h2007);
            tick();
        end
        full = 1'b0;
        #1;
        check("bp_resume_we", {31'd0, we}, 32'd1);
        check("bp_resume_data", {16'd0, data}, 32'h2007);
        tick();
        exp_count++;
        check("bp_done_busy", {31'd0, busy}, 32'd0);
        check("bp_done_count", {16'd0, cmd_count}, exp_count);

        // Mid-command reset after two RECT words were consumed.
        req_op = 2'd1; req_x = 10'd10; req_y = 9'd20; req_w = 10'd30; req_h = 9'd40; req_color = 3'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mr_pending_data", {16'd0, data}, 32'h0014);
        reset = 1'b0;
        tick();
        check("mr_we", {31'd0, we}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_count", {16'd0, cmd_count}, 32'd0);
        reset = 1'b1;
        tick();
        exp_count = 0;
        clr.op = 2'd2; clr.x = 10'd0; clr.y = 9'd0; clr.w = 10'd0; clr.h = 9'd0; clr.c = 3'd1;
        clr.n = 1; clr.drop = 1'b0;
        clr.words[0] = 16'h2001; clr.words[1] = 16'h0; clr.words[2] = 16'h0;
        clr.words[3] = 16'h0; clr.words[4] = 16'h0;
        run_vec(clr, "mr_clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/draw_cmd_writer.md
# draw_cmd_writer

Producer side of the draw-command word stream consumed by `DrawUnit`. It accepts one high-level draw request at a time from the CPU/control side over a valid/ready handshake. It serialises each request into 16-bit command words and writes them into `DrawUnit` using its `we`/`data`/`full` write port. It never writes while `full` is high.

## Interface
- `SCREEN_W`, default 640: horizontal pixel count; x field is 10 bits.
- `SCREEN_H`, default 480: vertical pixel count; y field is 9 bits.
- `COUNT_W`, default 16: width of `cmd_count`.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; the block is in reset while `reset`==0 at a rising edge.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_op`  in  2  0=NOP, 1=RECT, 2=CLEAR, 3=reserved (treated as NOP).
- `req_x`  in  10  rectangle left edge.
- `req_y`  in  9  rectangle top edge.
- `req_w`  in  10  rectangle width.
- `req_h`  in  9  rectangle height.
- `req_color`  in  3  RGB color.
- `full`  in  1  `DrawUnit` input buffer full; combinational from the consumer.
- `we`  out  1  write strobe to `DrawUnit`.
- `data`  out  16  command word to `DrawUnit`.
- `busy`  out  1  a command is being serialised.
- `dropped`  out  1  one-cycle pulse when a request is discarded.
- `cmd_count`  out  COUNT_W  commands fully written; wraps modulo 2^COUNT_W.

## Operation
- Word formats:
  - header = {opcode[3:0], 9'b0, color[2:0]}, with opcode 4'h1 for RECT and 4'h2 for CLEAR.
  - RECT is followed by {6'b0,x}, {7'b0,y}, {6'b0,w}, {7'b0,h}, in that order.
- Word counts: RECT is 5 words; CLEAR is 1 word.
- States:
  - IDLE: `req_ready`=1.
  - Acceptance is `req_valid & req_ready`. The request fields are latched on that edge.
  - NOP goes to IDLE, with no words and no pulse.
  - A RECT with w==0 or h==0 is discarded: `dropped` pulses, state stays IDLE.
  - Any other request goes to SEND with word index 0.
- SEND:
  - `data` = word[index], driven from latched fields.
  - `we` = ~`full`, combinational.
  - A word is consumed on an edge with `we`=1. On that edge the index increments.
  - On the last word: `cmd_count` increments and the state returns to IDLE.
- If `full`=1, the current word and index hold; there is no timeout.
- Request inputs are ignored outside IDLE.
- Reset values: `we`=0, `data`=0, `req_ready`=0 while in reset and 1 from the first cycle after reset, `busy`=0, `dropped`=0, `cmd_count`=0, state IDLE.
- Reset mid-command abandons the partial command; `DrawUnit` shares the same reset, so no resynchronisation word is emitted.

## Timing
- Accept at edge N. First word visible in cycle N+1.
- RECT with `full`=0 throughout: words are written on edges N+1..N+5; `req_ready`=1 from cycle N+6.
- CLEAR: written on edge N+1; `req_ready`=1 from N+2.
- Dropped request: `dropped`=1 in cycle N+1 only; `req_ready` stays 1, so a new request can be accepted at edge N+1.
- `cmd_count` increments on the edge consuming the last word and is visible the next cycle.
- `full` falling: the held word is written in that same cycle (zero-cycle resume).
- `busy` = (state == SEND).

## Configuration
- `DRAW_CLIP_EN` defined:
  - A RECT with x>=`SCREEN_W` or y>=`SCREEN_H` is dropped.
  - Otherwise w becomes min(w, `SCREEN_W`-x) and h becomes min(h, `SCREEN_H`-y) before serialisation.
  - Clipping is computed on the accept edge and adds no latency.
- `DRAW_CLIP_EN` undefined: x/y/w/h are forwarded as received. Only zero-size rectangles are dropped.

## Structure
- Package `draw_pkg`:
  - opcode constants (NOP, RECT, CLEAR) and the 4-bit header opcodes;
  - the field widths (10/9/3);
  - the RECT/CLEAR word counts;
  - the state enum (IDLE, SEND).
- Sub-module `draw_clip`: combinational clipper `(x,y,w,h) -> (w',h',drop)`. It is instantiated only under `DRAW_CLIP_EN`.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with `req_valid`=1 -> `we`=0, `data`=0, `req_ready`=0, `cmd_count`=0; `req_ready`=1 the cycle after release.
- **RECT, full=0:** x=10, y=20, w=30, h=40, color=5 -> words 16'h1005, 16'h000A, 16'h0014, 16'h001E, 16'h0028 on 5 consecutive edges; `cmd_count`=1.
- **Backpressure:** CLEAR color=7 with `full`=1 for 4 cycles -> `we`=0 and `data`=16'h2007 held; the single write occurs in the cycle `full` drops.
- **Zero-size:** RECT w=0 -> no `we`; `dropped` pulses once; `cmd_count` unchanged.
- **Clipping (`DRAW_CLIP_EN`):** x=600, y=470, w=100, h=50 -> w word 16'h0028, h word 16'h000A. x=640 -> dropped.
- **Mid-command reset:** reset=0 after the 2nd RECT word -> `we`=0 next cycle; after release, the next CLEAR emits exactly one word and `cmd_count`=1.
